// File: rtl/aoc25_11_pkg.sv
// Shared types for the day-11 path counter and the adjacency map it queries.
// Defaults here seed the top-level parameters.
package aoc25_11_pkg;

    localparam int DEFAULT_MAX_NODES   = 1024;
    localparam int DEFAULT_NODE_WIDTH  = $clog2(DEFAULT_MAX_NODES);
    localparam int DEFAULT_COUNT_WIDTH = 48;
    localparam int DEFAULT_STACK_DEPTH = 4096;

    typedef logic [DEFAULT_NODE_WIDTH-1:0]  node_t;
    typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        M_UNVISITED   = 2'd0,
        M_IN_PROGRESS = 2'd1,
        M_DONE        = 2'd2
    } memo_state_t;

    typedef struct packed {
        node_t node;
        logic  expanded;
    } stack_entry_t;

endpackage

// File: rtl/lifo_stack.sv
// DFS work stack: single-entry push or pop per cycle, popped data registered.
// Only the pointer is reset; storage contents are don't-care until written.
module lifo_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_dec;

    assign empty   = (ptr == '0);
    assign full    = (ptr == PW'(DEPTH));
    assign ptr_dec = ptr - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (push && !full)
            ptr <= ptr + 1'b1;
        else if (pop && !empty)
            ptr <= ptr_dec;
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[ptr[AW-1:0]] <= push_data;
        if (pop && !empty)
            pop_data <= mem[ptr_dec[AW-1:0]];
    end

endmodule

// File: rtl/path_counter.sv
// Counts distinct directed paths start_node -> target_node with an iterative
// memoized DFS over the adjacency map's query/reply interface.
module path_counter
    import aoc25_11_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NODE_WIDTH-1:0]  start_node,
    input  logic [NODE_WIDTH-1:0]  target_node,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] path_count,
    output logic [1:0]             error,
    output logic                   overflow,
    input  logic                   query_ready,
    output logic                   query_valid,
    output logic [NODE_WIDTH-1:0]  query_data,
    input  logic                   reply_valid,
    input  logic [NODE_WIDTH-1:0]  reply_data,
    input  logic                   reply_last,
    input  logic                   reply_no_edges_found,
    output logic                   reply_ready
);
    localparam int MW = 2 + COUNT_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_POP, S_POP_RD, S_DISPATCH,
        S_EXPAND, S_SUM, S_WRITE, S_FINAL, S_DONE
    } state_t;

    state_t state, state_n;
    logic                   armed, qsent, noedge, drain, acc_vld, cur_exp;
    logic [NODE_WIDTH-1:0]  start_q, target_q, clr_idx, cur_node;
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH:0]   sum_w;

    logic [MW-1:0]         memo [MAX_NODES];
    logic [MW-1:0]         memo_rd, memo_wdata;
    logic                  memo_we;
    logic [NODE_WIDTH-1:0] memo_addr;
    memo_state_t           rd_state;
    logic [COUNT_WIDTH-1:0] rd_count;

    logic                st_push, st_pop, st_clear, st_empty, st_full;
    logic [NODE_WIDTH:0] st_din, st_dout;
    logic                beat, discard;

    lifo_stack #(.WIDTH(NODE_WIDTH + 1), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk), .rst_n(rst_n), .clear(st_clear), .push(st_push), .pop(st_pop),
        .push_data(st_din), .pop_data(st_dout), .empty(st_empty), .full(st_full)
    );

    // Single-port memo: a write cycle suppresses the read.
    always_ff @(posedge clk) begin
        if (memo_we)
            memo[memo_addr] <= memo_wdata;
        else
            memo_rd <= memo[memo_addr];
    end

    assign rd_state   = memo_state_t'(memo_rd[MW-1 -: 2]);
    assign rd_count   = memo_rd[COUNT_WIDTH-1:0];
    assign sum_w      = {1'b0, acc} + {1'b0, rd_count};
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign query_data = cur_node;
    assign beat       = reply_valid && reply_ready;
    assign discard    = reply_no_edges_found || noedge;

    always_comb begin
        state_n     = state;
        memo_we     = 1'b0;
        memo_addr   = cur_node;
        memo_wdata  = '0;
        st_push     = 1'b0;
        st_pop      = 1'b0;
        st_clear    = 1'b0;
        st_din      = {cur_node, 1'b1};
        query_valid = 1'b0;
        reply_ready = 1'b0;
        case (state)
            S_IDLE: if (start && armed) begin
                st_clear = 1'b1;
                state_n  = S_CLEAR;
            end
            S_CLEAR: begin
                memo_we    = 1'b1;
                memo_addr  = clr_idx;
                memo_wdata = {M_UNVISITED, COUNT_WIDTH'(0)};
                if (clr_idx == NODE_WIDTH'(MAX_NODES - 1)) begin
                    st_push = 1'b1;
                    st_din  = {start_q, 1'b0};
                    state_n = S_POP;
                end
            end
            S_POP: begin
                memo_addr = start_q;
                if (st_empty) state_n = S_FINAL;
                else begin
                    st_pop  = 1'b1;
                    state_n = S_POP_RD;
                end
            end
            S_POP_RD: begin
                memo_addr = st_dout[NODE_WIDTH:1];
                state_n   = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (rd_state == M_DONE)
                    state_n = S_POP;
                else if (!cur_exp && cur_node == target_q) begin
                    memo_we    = 1'b1;
                    memo_wdata = {M_DONE, COUNT_WIDTH'(1)};
                    state_n    = S_POP;
                end else if (!cur_exp && rd_state == M_UNVISITED) begin
                    memo_we    = 1'b1;
                    memo_wdata = {M_IN_PROGRESS, COUNT_WIDTH'(0)};
                    st_push    = 1'b1;
                    state_n    = st_full ? S_DONE : S_EXPAND;
                end else if (!cur_exp)
                    state_n = S_DONE;   // revisiting an open node: not a DAG
                else
                    state_n = S_SUM;
            end
            S_EXPAND: begin
                query_valid = !qsent && query_ready;
                reply_ready = qsent;
                if (beat && !discard) begin
                    st_push = 1'b1;
                    st_din  = {reply_data, 1'b0};
                end
                // a full stack keeps draining the reply so the map is left idle
                if (beat && reply_last)
                    state_n = (error[1] || (st_push && st_full)) ? S_DONE : S_POP;
            end
            S_SUM: begin
                query_valid = !qsent && query_ready;
                reply_ready = qsent && !drain;
                if (beat && !discard) memo_addr = reply_data;
                if (drain) state_n = S_WRITE;
            end
            S_WRITE: begin
                memo_we    = 1'b1;
                memo_wdata = {M_DONE, acc};
                state_n    = S_POP;
            end
            S_FINAL: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            start_q    <= '0;
            target_q   <= '0;
            clr_idx    <= '0;
            cur_node   <= '0;
            cur_exp    <= 1'b0;
            qsent      <= 1'b0;
            noedge     <= 1'b0;
            drain      <= 1'b0;
            acc_vld    <= 1'b0;
            acc        <= '0;
            path_count <= '0;
            error      <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_n;
            armed <= 1'b1;
            if (st_push && st_full) error[1] <= 1'b1;
            case (state)
                S_IDLE: if (state_n == S_CLEAR) begin
                    start_q    <= start_node;
                    target_q   <= target_node;
                    clr_idx    <= '0;
                    path_count <= '0;
                    error      <= '0;
                    overflow   <= 1'b0;
                end
                S_CLEAR:  clr_idx <= clr_idx + 1'b1;
                S_POP_RD: begin
                    cur_node <= st_dout[NODE_WIDTH:1];
                    cur_exp  <= st_dout[0];
                end
                S_DISPATCH: begin
                    qsent   <= 1'b0;
                    noedge  <= 1'b0;
                    drain   <= 1'b0;
                    acc_vld <= 1'b0;
                    acc     <= '0;
                    if (!cur_exp && cur_node != target_q && rd_state == M_IN_PROGRESS)
                        error[0] <= 1'b1;
                end
                S_EXPAND, S_SUM: begin
                    if (query_valid) qsent <= 1'b1;
                    if (beat && reply_no_edges_found) noedge <= 1'b1;
                    if (beat && reply_last) drain <= 1'b1;
                    acc_vld <= beat && !discard && (state == S_SUM);
                    if (acc_vld && rd_state == M_DONE) begin
                        if (sum_w[COUNT_WIDTH]) begin
                            acc      <= '1;
                            overflow <= 1'b1;
                        end else
                            acc <= sum_w[COUNT_WIDTH-1:0];
                    end
                end
                S_FINAL: path_count <= rd_count;
                default: ;
            endcase
        end
    end

endmodule
